// File: rtl/mem_req_sequencer_if.sv
// Token bundle of one memory-port sequencer: graph-side request/return channels and the
// issue channels to the memory port. Every token is {valid, payload}.
interface mem_req_sequencer_if #(
    parameter int ADDR_LENGTH      = 5,
    parameter int MEM_ENTRY_LENGTH = 16
);
    logic [ADDR_LENGTH:0]      req_addr;
    logic                      req_addr_stop;
    logic [1:0]                req_wr;
    logic                      req_wr_stop;
    logic [MEM_ENTRY_LENGTH:0] req_data;
    logic                      req_data_stop;
    logic [ADDR_LENGTH:0]      addr;
    logic                      addr_stop;
    logic [MEM_ENTRY_LENGTH:0] in_data;
    logic                      in_data_stop;
    logic [1:0]                wren;
    logic                      wren_stop;
    logic [MEM_ENTRY_LENGTH:0] out_data;
    logic                      down_stop;
    logic [MEM_ENTRY_LENGTH:0] ld_data;
    logic                      ld_data_stop;

    // master: the surrounding graph and memory port; slave: the sequencer itself
    modport master (
        output req_addr, req_wr, req_data, addr_stop, in_data_stop, wren_stop,
               out_data, ld_data_stop,
        input  req_addr_stop, req_wr_stop, req_data_stop, addr, in_data, wren,
               down_stop, ld_data
    );

    modport slave (
        input  req_addr, req_wr, req_data, addr_stop, in_data_stop, wren_stop,
               out_data, ld_data_stop,
        output req_addr_stop, req_wr_stop, req_data_stop, addr, in_data, wren,
               down_stop, ld_data
    );
endinterface

// File: rtl/mem_req_sequencer.sv
// Joins address/write/data request tokens into an in-order request queue, issues the head
// request to a memory port channel by channel, and forwards load results back to the graph.
module mem_req_sequencer #(
    parameter int ADDR_LENGTH      = 5,
    parameter int MEM_ENTRY_LENGTH = 16,
    parameter int DEPTH            = 4,
    parameter int MAX_LOADS        = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_req_sequencer_if.slave bus
);
    localparam int A  = ADDR_LENGTH;
    localparam int D  = MEM_ENTRY_LENGTH;
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam int LW = $clog2(MAX_LOADS + 1);

    typedef struct packed {
        logic [A-1:0] addr;
        logic         wr;
        logic [D-1:0] data;
    } req_t;

    req_t          queue_mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic          active_reg;
    logic          addr_sent_reg;
    logic          data_sent_reg;
    logic          wren_sent_reg;
    logic [LW-1:0] loads_out_reg;
    logic [LW-1:0] loads_out_next;
    logic          ld_valid_reg;
    logic [D-1:0]  ld_payload_reg;
    logic          err_sticky;

    // ---------------- request join ----------------
    logic req_is_store;
    logic req_complete;
    logic q_empty;
    logic q_full;
    logic accept;
    req_t wr_entry;

    assign req_is_store = bus.req_wr[0];
    assign req_complete = bus.req_addr[A] && bus.req_wr[1] && (!req_is_store || bus.req_data[D]);
    assign q_empty      = (wr_ptr_reg == rd_ptr_reg);
    assign q_full       = (wr_ptr_reg[IW-1:0] == rd_ptr_reg[IW-1:0]) &&
                          (wr_ptr_reg[IW] != rd_ptr_reg[IW]);
    // active_reg keeps every stop high until the first clock edge after reset release
    assign accept       = active_reg && req_complete && !q_full;

    assign bus.req_addr_stop = !accept;
    assign bus.req_wr_stop   = !accept;
    assign bus.req_data_stop = !(accept && req_is_store);

    assign wr_entry = '{addr: bus.req_addr[A-1:0],
                        wr:   req_is_store,
                        data: req_is_store ? bus.req_data[D-1:0] : '0};

    always_ff @(posedge clk) begin
        if (accept) begin
            queue_mem[wr_ptr_reg[IW-1:0]] <= wr_entry;
        end
    end

    // ---------------- head issue ----------------
    req_t head;
    logic load_blocked;
    logic head_live;
    logic addr_v, data_v, wren_v;
    logic addr_xfer, data_xfer, wren_xfer;
    logic retire;
    logic load_issue;

    assign head         = queue_mem[rd_ptr_reg[IW-1:0]];
    assign load_blocked = !head.wr && (loads_out_reg == LW'(MAX_LOADS));
    assign head_live    = active_reg && !q_empty && !load_blocked;

    assign addr_v = head_live && !addr_sent_reg;
    assign data_v = head_live && head.wr && !data_sent_reg;
    assign wren_v = head_live && !wren_sent_reg;

    assign bus.addr    = addr_v ? {1'b1, head.addr} : '0;
    assign bus.in_data = data_v ? {1'b1, head.data} : '0;
    assign bus.wren    = wren_v ? {1'b1, head.wr}   : '0;

    assign addr_xfer = addr_v && !bus.addr_stop;
    assign data_xfer = data_v && !bus.in_data_stop;
    assign wren_xfer = wren_v && !bus.wren_stop;

    // Retire counts channels moving this cycle so a fully accepted head leaves in one cycle
    assign retire = head_live &&
                    (addr_sent_reg || addr_xfer) &&
                    (wren_sent_reg || wren_xfer) &&
                    (!head.wr || data_sent_reg || data_xfer);
    assign load_issue = retire && !head.wr;

    // ---------------- return path ----------------
    logic down_stop_int;
    logic ret_xfer;
    logic ret_accept;
    logic ret_drop;
    logic ld_xfer;

    assign down_stop_int = !active_reg || (ld_valid_reg && bus.ld_data_stop);
    assign ret_xfer      = bus.out_data[D] && !down_stop_int;
    assign ret_accept    = ret_xfer && (loads_out_reg != '0);
    assign ret_drop      = ret_xfer && (loads_out_reg == '0);
    assign ld_xfer       = ld_valid_reg && !bus.ld_data_stop;

    assign bus.down_stop = down_stop_int;
    assign bus.ld_data   = ld_valid_reg ? {1'b1, ld_payload_reg} : '0;

    always_comb begin
        loads_out_next = loads_out_reg;
        if (load_issue && !ret_accept) begin
            loads_out_next = loads_out_reg + 1'b1;
        end else if (!load_issue && ret_accept) begin
            loads_out_next = loads_out_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_reg     <= 1'b0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            addr_sent_reg  <= 1'b0;
            data_sent_reg  <= 1'b0;
            wren_sent_reg  <= 1'b0;
            loads_out_reg  <= '0;
            ld_valid_reg   <= 1'b0;
            ld_payload_reg <= '0;
            err_sticky     <= 1'b0;
        end else begin
            active_reg    <= 1'b1;
            loads_out_reg <= loads_out_next;
            if (accept) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (retire) begin
                rd_ptr_reg    <= rd_ptr_reg + 1'b1;
                addr_sent_reg <= 1'b0;
                data_sent_reg <= 1'b0;
                wren_sent_reg <= 1'b0;
            end else begin
                if (addr_xfer) addr_sent_reg <= 1'b1;
                if (data_xfer) data_sent_reg <= 1'b1;
                if (wren_xfer) wren_sent_reg <= 1'b1;
            end
            if (ret_accept) begin
                ld_valid_reg   <= 1'b1;
                ld_payload_reg <= bus.out_data[D-1:0];
            end else if (ld_xfer) begin
                ld_valid_reg <= 1'b0;
            end
            // A result with no load outstanding cannot belong to any request
            if (ret_drop) begin
                err_sticky <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_req_sequencer.sv
// Directed bench for mem_req_sequencer: a per-cycle vector table for store/load basics,
// then hand-written sequences for split acceptance, queue full, load limit and reset.
module tb_mem_req_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    mem_req_sequencer_if #(.ADDR_LENGTH(5), .MEM_ENTRY_LENGTH(16)) bus ();

    mem_req_sequencer #(
        .ADDR_LENGTH(5),
        .MEM_ENTRY_LENGTH(16),
        .DEPTH(4),
        .MAX_LOADS(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [5:0]  req_addr;
        logic [1:0]  req_wr;
        logic [16:0] req_data;
        logic        addr_stop;
        logic        in_data_stop;
        logic        wren_stop;
        logic [16:0] out_data;
        logic        ld_data_stop;
        logic        e_ras;
        logic        e_rws;
        logic        e_rds;
        logic [5:0]  e_addr;
        logic [16:0] e_in;
        logic [1:0]  e_wren;
        logic        e_ds;
        logic [16:0] e_ld;
    } vec_t;

    vec_t vecs [9];

    int checks = 0;
    int failures = 0;
    int wren_cnt = 0;
    logic [4:0]  addr_log [$];
    logic [15:0] data_log [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_stops(input string tag, input logic ras, input logic rws, input logic rds);
        check({tag, ".req_addr_stop"}, 32'(bus.req_addr_stop), 32'(ras));
        check({tag, ".req_wr_stop"},   32'(bus.req_wr_stop),   32'(rws));
        check({tag, ".req_data_stop"}, 32'(bus.req_data_stop), 32'(rds));
    endtask

    task automatic expect_out(input string tag, input logic [5:0] ea, input logic [16:0] ei,
                              input logic [1:0] ew, input logic eds, input logic [16:0] eld);
        check({tag, ".addr"},      32'(bus.addr),      32'(ea));
        check({tag, ".in_data"},   32'(bus.in_data),   32'(ei));
        check({tag, ".wren"},      32'(bus.wren),      32'(ew));
        check({tag, ".down_stop"}, 32'(bus.down_stop), 32'(eds));
        check({tag, ".ld_data"},   32'(bus.ld_data),   32'(eld));
    endtask

    task automatic set_idle();
        bus.req_addr     = '0;
        bus.req_wr       = '0;
        bus.req_data     = '0;
        bus.addr_stop    = 1'b0;
        bus.in_data_stop = 1'b0;
        bus.wren_stop    = 1'b0;
        bus.out_data     = '0;
        bus.ld_data_stop = 1'b0;
    endtask

    task automatic push_req(input logic [4:0] a, input logic st, input logic [15:0] d);
        bus.req_addr = {1'b1, a};
        bus.req_wr   = {1'b1, st};
        bus.req_data = st ? {1'b1, d} : 17'h0;
    endtask

    task automatic clear_req();
        bus.req_addr = '0;
        bus.req_wr   = '0;
        bus.req_data = '0;
    endtask

    // Logs memory-port transfers just before the edge, then advances one cycle
    task automatic next_cycle();
        if (bus.addr[5] && !bus.addr_stop)       addr_log.push_back(bus.addr[4:0]);
        if (bus.in_data[16] && !bus.in_data_stop) data_log.push_back(bus.in_data[15:0]);
        if (bus.wren[1] && !bus.wren_stop)        wren_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        addr_log.delete();
        data_log.delete();
        wren_cnt = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                req_addr req_wr req_data  as in ws out_data  lds  ras rws rds addr   in_data   wren  ds ld
        vecs[0] = '{6'h00, 2'b00, 17'h00000, 0, 0, 0, 17'h00000, 0,  1, 1, 1, 6'h00, 17'h00000, 2'b00, 0, 17'h00000};
        vecs[1] = '{6'h36, 2'b11, 17'h00000, 0, 0, 0, 17'h00000, 0,  1, 1, 1, 6'h00, 17'h00000, 2'b00, 0, 17'h00000};
        vecs[2] = '{6'h36, 2'b11, 17'h1ACDC, 0, 0, 0, 17'h00000, 0,  0, 0, 0, 6'h00, 17'h00000, 2'b00, 0, 17'h00000};
        vecs[3] = '{6'h00, 2'b00, 17'h00000, 0, 0, 0, 17'h00000, 0,  1, 1, 1, 6'h36, 17'h1ACDC, 2'b11, 0, 17'h00000};
        vecs[4] = '{6'h36, 2'b10, 17'h11234, 0, 0, 0, 17'h00000, 0,  0, 0, 1, 6'h00, 17'h00000, 2'b00, 0, 17'h00000};
        vecs[5] = '{6'h00, 2'b00, 17'h00000, 0, 0, 0, 17'h00000, 0,  1, 1, 1, 6'h36, 17'h00000, 2'b10, 0, 17'h00000};
        vecs[6] = '{6'h00, 2'b00, 17'h00000, 0, 0, 0, 17'h1ACDC, 0,  1, 1, 1, 6'h00, 17'h00000, 2'b00, 0, 17'h00000};
        vecs[7] = '{6'h00, 2'b00, 17'h00000, 0, 0, 0, 17'h00000, 0,  1, 1, 1, 6'h00, 17'h00000, 2'b00, 0, 17'h1ACDC};
        vecs[8] = '{6'h00, 2'b00, 17'h00000, 0, 0, 0, 17'h00000, 0,  1, 1, 1, 6'h00, 17'h00000, 2'b00, 0, 17'h00000};

        // ---- reset: outputs quiet and stops high even with complete requests offered ----
        set_idle();
        #1 rst_n = 1'b0;
        push_req(5'd22, 1'b1, 16'hACDC);
        bus.out_data = 17'h1BEEF;
        #1;
        expect_stops("rst", 1'b1, 1'b1, 1'b1);
        expect_out("rst", 6'h00, 17'h0, 2'b00, 1'b1, 17'h0);
        repeat (2) @(posedge clk);
        #1;
        expect_stops("rst_hold", 1'b1, 1'b1, 1'b1);
        set_idle();
        rst_n = 1'b1;
        #1;
        expect_stops("rst_rel", 1'b1, 1'b1, 1'b1);
        check("rst_rel.down_stop", 32'(bus.down_stop), 32'd1);
        $display("reset sequence applied");
        next_cycle();

        // ---- table: partial join, store, load, load return ----
        for (int i = 0; i < 9; i++) begin
            bus.req_addr     = vecs[i].req_addr;
            bus.req_wr       = vecs[i].req_wr;
            bus.req_data     = vecs[i].req_data;
            bus.addr_stop    = vecs[i].addr_stop;
            bus.in_data_stop = vecs[i].in_data_stop;
            bus.wren_stop    = vecs[i].wren_stop;
            bus.out_data     = vecs[i].out_data;
            bus.ld_data_stop = vecs[i].ld_data_stop;
            #1;
            expect_stops($sformatf("v%0d", i), vecs[i].e_ras, vecs[i].e_rws, vecs[i].e_rds);
            expect_out($sformatf("v%0d", i), vecs[i].e_addr, vecs[i].e_in, vecs[i].e_wren,
                       vecs[i].e_ds, vecs[i].e_ld);
            $display("vec %0d addr=%h in_data=%h wren=%h ld_data=%h", i, bus.addr, bus.in_data,
                     bus.wren, bus.ld_data);
            next_cycle();
        end
        check("v.loads_out", 32'(dut.loads_out_reg), 32'd0);

        // ---- split acceptance: addr goes first, in_data/wren held three cycles ----
        set_idle();
        clear_logs();
        push_req(5'd3, 1'b1, 16'h1111);
        #1;
        expect_stops("split_push", 1'b0, 1'b0, 1'b0);
        next_cycle();
        clear_req();
        bus.in_data_stop = 1'b1;
        bus.wren_stop    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            expect_out($sformatf("split%0d", k), (k == 0) ? 6'h23 : 6'h00, 17'h11111, 2'b11,
                       1'b0, 17'h0);
            next_cycle();
        end
        bus.in_data_stop = 1'b0;
        bus.wren_stop    = 1'b0;
        #1;
        expect_out("split_rel", 6'h00, 17'h11111, 2'b11, 1'b0, 17'h0);
        next_cycle();
        #1;
        expect_out("split_done", 6'h00, 17'h0, 2'b00, 1'b0, 17'h0);
        check("split.addr_count", 32'(addr_log.size()), 32'd1);
        check("split.data_count", 32'(data_log.size()), 32'd1);
        check("split.wren_count", 32'(wren_cnt), 32'd1);
        $display("split acceptance sequence applied: addr=%0d data=%0d wren=%0d",
                 addr_log.size(), data_log.size(), wren_cnt);

        // ---- queue full: wren held, five stores offered ----
        set_idle();
        clear_logs();
        bus.wren_stop = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push_req(5'(10 + k), 1'b1, 16'(16'h5000 + k));
            #1;
            expect_stops($sformatf("full_push%0d", k), 1'b0, 1'b0, 1'b0);
            next_cycle();
        end
        push_req(5'd14, 1'b1, 16'h5004);
        for (int k = 0; k < 2; k++) begin
            #1;
            expect_stops($sformatf("full_hold%0d", k), 1'b1, 1'b1, 1'b1);
            next_cycle();
        end
        bus.wren_stop = 1'b0;
        #1;
        expect_stops("full_rel0", 1'b1, 1'b1, 1'b1);
        next_cycle();
        #1;
        expect_stops("full_rel1", 1'b0, 1'b0, 1'b0);
        next_cycle();
        clear_req();
        repeat (8) begin
            #1;
            next_cycle();
        end
        check("full.addr_count", 32'(addr_log.size()), 32'd5);
        check("full.data_count", 32'(data_log.size()), 32'd5);
        check("full.wren_count", 32'(wren_cnt), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < addr_log.size()) check($sformatf("full.addr_order%0d", k), 32'(addr_log[k]), 32'(10 + k));
            if (k < data_log.size()) check($sformatf("full.data_order%0d", k), 32'(data_log[k]), 32'(16'h5000 + k));
        end
        $display("queue full sequence applied: %0d requests issued", addr_log.size());

        // ---- load limit: third load waits for a returned result ----
        set_idle();
        clear_logs();
        for (int k = 1; k <= 3; k++) begin
            push_req(5'(k), 1'b0, 16'h0);
            #1;
            expect_stops($sformatf("ld_push%0d", k), 1'b0, 1'b0, 1'b1);
            next_cycle();
        end
        clear_req();
        for (int k = 0; k < 2; k++) begin
            #1;
            expect_out($sformatf("ld_block%0d", k), 6'h00, 17'h0, 2'b00, 1'b0, 17'h0);
            next_cycle();
        end
        check("ld.loads_out_max", 32'(dut.loads_out_reg), 32'd2);
        check("ld.issued", 32'(addr_log.size()), 32'd2);
        bus.out_data = 17'h1AAAA;
        #1;
        expect_out("ld_ret", 6'h00, 17'h0, 2'b00, 1'b0, 17'h0);
        next_cycle();
        bus.out_data = '0;
        #1;
        expect_out("ld_third", 6'h23, 17'h0, 2'b10, 1'b0, 17'h1AAAA);
        next_cycle();
        check("ld.loads_out_after", 32'(dut.loads_out_reg), 32'd2);
        $display("load limit sequence applied: loads_out=%0d", dut.loads_out_reg);

        // ---- return buffer backpressure ----
        bus.out_data     = 17'h1BBBB;
        bus.ld_data_stop = 1'b1;
        #1;
        expect_out("bp0", 6'h00, 17'h0, 2'b00, 1'b0, 17'h0);
        next_cycle();
        bus.out_data = 17'h1CCCC;
        #1;
        expect_out("bp1", 6'h00, 17'h0, 2'b00, 1'b1, 17'h1BBBB);
        next_cycle();
        bus.ld_data_stop = 1'b0;
        #1;
        expect_out("bp2", 6'h00, 17'h0, 2'b00, 1'b0, 17'h1BBBB);
        next_cycle();
        bus.out_data = '0;
        #1;
        expect_out("bp3", 6'h00, 17'h0, 2'b00, 1'b0, 17'h1CCCC);
        check("bp.loads_out", 32'(dut.loads_out_reg), 32'd0);
        next_cycle();
        $display("return backpressure sequence applied");

        // ---- stray result with nothing outstanding ----
        check("drop.err_before", 32'(dut.err_sticky), 32'd0);
        bus.out_data = 17'h1DEAD;
        #1;
        next_cycle();
        bus.out_data = '0;
        #1;
        check("drop.err_after", 32'(dut.err_sticky), 32'd1);
        expect_out("drop", 6'h00, 17'h0, 2'b00, 1'b0, 17'h0);
        check("drop.loads_out", 32'(dut.loads_out_reg), 32'd0);
        next_cycle();
        $display("stray result sequence applied");

        // ---- reset mid-operation discards a partially sent request ----
        set_idle();
        bus.wren_stop = 1'b1;
        push_req(5'd7, 1'b1, 16'h7777);
        #1;
        next_cycle();
        clear_req();
        #1;
        expect_out("mid_pre", 6'h27, 17'h17777, 2'b11, 1'b0, 17'h0);
        next_cycle();
        rst_n = 1'b0;
        push_req(5'd8, 1'b1, 16'h8888);
        #1;
        expect_out("mid_rst", 6'h00, 17'h0, 2'b00, 1'b1, 17'h0);
        expect_stops("mid_rst", 1'b1, 1'b1, 1'b1);
        next_cycle();
        set_idle();
        rst_n = 1'b1;
        #1;
        next_cycle();
        #1;
        expect_out("mid_after", 6'h00, 17'h0, 2'b00, 1'b0, 17'h0);
        check("mid.err_cleared", 32'(dut.err_sticky), 32'd0);
        next_cycle();
        $display("mid-operation reset sequence applied");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
